// File: rtl/key_action_pkg.sv
// key_action_pkg: set-2 scan codes, action/state enums and key decode
// shared by key_action_ctrl and key_stable_filter
package key_action_pkg;

  localparam logic [7:0] SC_NONE  = 8'h00;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_J     = 8'h3B;
  localparam logic [7:0] SC_K     = 8'h42;
  localparam logic [7:0] SC_E     = 8'h24;
  localparam logic [7:0] SC_1     = 8'h16;
  localparam logic [7:0] SC_2     = 8'h1E;
  localparam logic [7:0] SC_3     = 8'h26;
  localparam logic [7:0] SC_4     = 8'h25;
  localparam logic [7:0] SC_5     = 8'h2E;
  localparam logic [7:0] SC_6     = 8'h36;
  localparam logic [7:0] SC_7     = 8'h3D;
  localparam logic [7:0] SC_8     = 8'h3E;
  localparam logic [7:0] SC_9     = 8'h46;
  localparam logic [7:0] SC_ESC   = 8'h76;

  typedef enum logic [2:0] {
    ACT_LEFT,
    ACT_RIGHT,
    ACT_UP,
    ACT_DOWN,
    ACT_JUMP,
    ACT_BREAK,
    ACT_PLACE,
    ACT_INV
  } action_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT,
    ST_HELD
  } state_e;

  localparam logic [7:0] REPEAT_MASK = 8'b0110_1111;
  // actions still allowed to pulse while paused
  localparam logic [7:0] PAUSE_MASK  = 8'b1000_0000;

  typedef struct packed {
    logic    is_act;
    action_e act;
    logic    is_digit;
    logic [3:0] slot;
    logic    is_esc;
  } key_info_t;

  function automatic key_info_t decode_key(
    input logic [7:0] c
  );
    key_info_t k;
    k = '0;
    case (c)
      SC_A:     begin k.is_act = 1'b1; k.act = ACT_LEFT;  end
      SC_D:     begin k.is_act = 1'b1; k.act = ACT_RIGHT; end
      SC_W:     begin k.is_act = 1'b1; k.act = ACT_UP;    end
      SC_S:     begin k.is_act = 1'b1; k.act = ACT_DOWN;  end
      SC_SPACE: begin k.is_act = 1'b1; k.act = ACT_JUMP;  end
      SC_J:     begin k.is_act = 1'b1; k.act = ACT_BREAK; end
      SC_K:     begin k.is_act = 1'b1; k.act = ACT_PLACE; end
      SC_E:     begin k.is_act = 1'b1; k.act = ACT_INV;   end
      SC_1:     begin k.is_digit = 1'b1; k.slot = 4'd0; end
      SC_2:     begin k.is_digit = 1'b1; k.slot = 4'd1; end
      SC_3:     begin k.is_digit = 1'b1; k.slot = 4'd2; end
      SC_4:     begin k.is_digit = 1'b1; k.slot = 4'd3; end
      SC_5:     begin k.is_digit = 1'b1; k.slot = 4'd4; end
      SC_6:     begin k.is_digit = 1'b1; k.slot = 4'd5; end
      SC_7:     begin k.is_digit = 1'b1; k.slot = 4'd6; end
      SC_8:     begin k.is_digit = 1'b1; k.slot = 4'd7; end
      SC_9:     begin k.is_digit = 1'b1; k.slot = 4'd8; end
      SC_ESC:   k.is_esc = 1'b1;
      default:  k = '0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/key_stable_filter.sv
// key_stable_filter: accepts a keycode once it has been sampled
// unchanged for STABLE_CYCLES consecutive cycles
module key_stable_filter
  import key_action_pkg::*;
#(
  parameter int STABLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] keycode,
  output logic [7:0] code,
  output logic       chg
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] FULL = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [7:0]    cand;
  logic [CW-1:0] cnt;

  // cnt holds the number of consecutive samples equal to cand
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand <= SC_NONE;
      cnt  <= '0;
      code <= SC_NONE;
      chg  <= 1'b0;
    end else begin
      chg <= 1'b0;
      if (keycode != cand) begin
        cand <= keycode;
        cnt  <= ONE;
      end else if (cnt != FULL) begin
        cnt <= cnt + ONE;
      end
      if (cnt == FULL && cand != code) begin
        code <= cand;
        chg  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_action_ctrl.sv
// key_action_ctrl: keycode -> held/press/repeat actions, hotbar, pause
// auto-repeat is built only when KEY_ACTION_REPEAT_EN is defined
module key_action_ctrl
  import key_action_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int REPEAT_DELAY  = 12_500_000,
  parameter int REPEAT_PERIOD = 2_500_000
) (
  input  logic       Clk,
  input  logic       Reset_h,
  input  logic [7:0] keycode,
  output logic [7:0] held,
  output logic [7:0] press,
  output logic [7:0] repeat_p,
  output logic [3:0] hotbar_sel,
  output logic       hotbar_valid,
  output logic       paused
);

  logic [7:0] code;
  logic       chg;

  key_stable_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk     (Clk),
    .rst     (Reset_h),
    .keycode (keycode),
    .code    (code),
    .chg     (chg)
  );

  key_info_t  info;
  logic [7:0] act_vec;
  logic [7:0] pmask;

  assign info    = decode_key(code);
  assign act_vec = info.is_act ? (8'b1 << info.act) : 8'h00;
  assign pmask   = paused ? PAUSE_MASK : 8'hFF;

  state_e     state;
  state_e     state_n;
  logic [7:0] press_n;
  logic [3:0] sel_n;
  logic       valid_n;
  logic       paused_n;

`ifdef KEY_ACTION_REPEAT_EN
  localparam int CMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] DLY_END = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PER_END = CW'(REPEAT_PERIOD - 1);
  localparam logic [CW-1:0] ONE     = CW'(1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [7:0]    rpt_n;
`endif

  always_comb begin
    state_n  = state;
    press_n  = '0;
    sel_n    = hotbar_sel;
    valid_n  = 1'b0;
    paused_n = paused;
`ifdef KEY_ACTION_REPEAT_EN
    cnt_n    = cnt;
    rpt_n    = '0;
`endif
    // a new accepted code restarts from IDLE in the same cycle
    if (chg) begin
      state_n = ST_IDLE;
      unique case (1'b1)
        info.is_act: begin
          press_n = act_vec & pmask;
`ifdef KEY_ACTION_REPEAT_EN
          state_n = ST_DELAY;
          cnt_n   = '0;
`else
          state_n = ST_HELD;
`endif
        end
        info.is_digit: begin
          sel_n   = info.slot;
          valid_n = 1'b1;
        end
        info.is_esc: paused_n = ~paused;
        default: ;
      endcase
    end else begin
      unique case (state)
`ifdef KEY_ACTION_REPEAT_EN
        ST_DELAY: begin
          if (cnt != DLY_END) begin
            cnt_n = cnt + ONE;
          end else if (REPEAT_MASK[info.act]) begin
            rpt_n   = act_vec & pmask;
            state_n = ST_REPEAT;
            cnt_n   = '0;
          end
        end
        ST_REPEAT: begin
          if (cnt == PER_END) begin
            rpt_n = act_vec & pmask;
            cnt_n = '0;
          end else begin
            cnt_n = cnt + ONE;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset_h) begin
    if (Reset_h) begin
      state        <= ST_IDLE;
      held         <= '0;
      press        <= '0;
      hotbar_sel   <= '0;
      hotbar_valid <= 1'b0;
      paused       <= 1'b0;
    end else begin
      state        <= state_n;
      held         <= act_vec;
      press        <= press_n;
      hotbar_sel   <= sel_n;
      hotbar_valid <= valid_n;
      paused       <= paused_n;
    end
  end

`ifdef KEY_ACTION_REPEAT_EN
  always_ff @(posedge Clk or posedge Reset_h) begin
    if (Reset_h) begin
      cnt      <= '0;
      repeat_p <= '0;
    end else begin
      cnt      <= cnt_n;
      repeat_p <= rpt_n;
    end
  end
`else
  assign repeat_p = '0;
`endif

endmodule

// File: tb/tb_key_action_ctrl.sv
// tb_key_action_ctrl: directed + random stimulus against a
// behavioural model of the key action controller
module tb_key_action_ctrl;

  localparam int S = 4;
  localparam int D = 20;
  localparam int R = 8;
`ifdef KEY_ACTION_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic       Clk;
  logic       Reset_h;
  logic [7:0] keycode;
  logic [7:0] held;
  logic [7:0] press;
  logic [7:0] repeat_p;
  logic [3:0] hotbar_sel;
  logic       hotbar_valid;
  logic       paused;

  key_action_ctrl #(
    .STABLE_CYCLES(S),
    .REPEAT_DELAY (D),
    .REPEAT_PERIOD(R)
  ) dut (
    .Clk          (Clk),
    .Reset_h      (Reset_h),
    .keycode      (keycode),
    .held         (held),
    .press        (press),
    .repeat_p     (repeat_p),
    .hotbar_sel   (hotbar_sel),
    .hotbar_valid (hotbar_valid),
    .paused       (paused)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int pass_cnt = 0;
  int total    = 0;
  bit chk_on   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h at %0t", nm, got, exp, $time);
  endtask

  function automatic int act_of(input logic [7:0] c);
    case (c)
      8'h1C: return 0;
      8'h23: return 1;
      8'h1D: return 2;
      8'h1B: return 3;
      8'h29: return 4;
      8'h3B: return 5;
      8'h42: return 6;
      8'h24: return 7;
      default: return -1;
    endcase
  endfunction

  function automatic int slot_of(input logic [7:0] c);
    logic [7:0] dig [9];
    dig = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
            8'h36, 8'h3D, 8'h3E, 8'h46};
    for (int i = 0; i < 9; i++) if (dig[i] == c) return i;
    return -1;
  endfunction

  // model state: accepted code from the last S samples
  logic [7:0] hist [$];
  logic [7:0] mc, mc_prev;
  logic [7:0] m_held, m_press, m_rpt;
  logic [3:0] m_sel;
  logic       m_valid, m_paused;
  int         ecount, press_edge;
  bit         live;

  always @(posedge Clk or posedge Reset_h) begin
    if (Reset_h) begin
      hist.delete();
      mc = 8'h00; mc_prev = 8'h00;
      m_held = 0; m_press = 0; m_rpt = 0;
      m_sel = 0; m_valid = 0; m_paused = 0;
      ecount = 0; press_edge = 0; live = 0;
    end else begin
      int a;
      int d;
      logic [7:0] nc;
      ecount++;
      a = act_of(mc);
      m_held  = (a >= 0) ? 8'(1 << a) : 8'h00;
      m_press = 0;
      m_rpt   = 0;
      m_valid = 0;
      if (mc != mc_prev) begin
        live = 0;
        if (a >= 0) begin
          m_press = (m_paused && a != 7) ? 8'h00 : 8'(1 << a);
          press_edge = ecount;
          live = 1;
        end else if (slot_of(mc) >= 0) begin
          m_sel = 4'(slot_of(mc));
          m_valid = 1;
        end else if (mc == 8'h76) begin
          m_paused = !m_paused;
        end
      end else if (REP_EN && live && a inside {0, 1, 2, 3, 5, 6}) begin
        d = ecount - press_edge;
        if (d >= D && (d - D) % R == 0 && !m_paused)
          m_rpt = 8'(1 << a);
      end
      nc = mc;
      if (hist.size() == S) begin
        nc = hist[0];
        foreach (hist[i]) if (hist[i] != hist[0]) nc = mc;
      end
      mc_prev = mc;
      mc = nc;
      hist.push_back(keycode);
      if (hist.size() > S) void'(hist.pop_front());
    end
  end

  always @(negedge Clk) begin
    if (chk_on) begin
      chk("held", held, m_held);
      chk("press", press, m_press);
      chk("repeat_p", repeat_p, m_rpt);
      chk("hotbar_sel", hotbar_sel, m_sel);
      chk("hotbar_valid", hotbar_valid, m_valid);
      chk("paused", paused, m_paused);
    end
  end

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic idle(input int n);
    keycode = 8'h00;
    repeat (n) step();
  endtask

  logic [7:0] pool [22];

  initial begin
    Reset_h = 1'b1;
    keycode = 8'h00;
    repeat (3) @(negedge Clk);
    chk("reset_outputs",
        {held, press, repeat_p, hotbar_sel, hotbar_valid, paused}, 0);
    Reset_h = 1'b0;
    chk_on  = 1'b1;

    // A held 60 cycles, then release
    keycode = 8'h1C;
    for (int k = 0; k < 60; k++) begin
      step();
      if (k == 4) chk("s1_held_pre", held, 8'h00);
      if (k == 5) begin
        chk("s1_held", held, 8'h01);
        chk("s1_press", press, 8'h01);
      end
      if (k == 6) chk("s1_press_once", press, 8'h00);
      if (k == 24) chk("s1_rpt_early", repeat_p, 8'h00);
      if (k == 25) chk("s1_rpt1", repeat_p, REP_EN ? 8'h01 : 8'h00);
      if (k == 32) chk("s1_rpt_gap", repeat_p, 8'h00);
      if (k == 33) chk("s1_rpt2", repeat_p, REP_EN ? 8'h01 : 8'h00);
      if (k == 57) chk("s1_rpt5", repeat_p, REP_EN ? 8'h01 : 8'h00);
    end
    keycode = 8'h00;
    for (int k = 60; k < 70; k++) begin
      step();
      if (k == 64) chk("s1_rel_pre", held, 8'h01);
      if (k == 65) begin
        chk("s1_rel", held, 8'h00);
        chk("s1_rel_nopress", press, 8'h00);
      end
    end

    // glitch shorter than the filter
    keycode = 8'h1C;
    repeat (3) step();
    keycode = 8'h00;
    for (int k = 0; k < 10; k++) begin
      step();
      if (k == 6) chk("glitch_held", held, 8'h00);
    end

    // hotbar digits
    keycode = 8'h26;
    for (int k = 0; k < 40; k++) begin
      step();
      if (k == 5) begin
        chk("hb3_sel", hotbar_sel, 4'd2);
        chk("hb3_valid", hotbar_valid, 1'b1);
      end
      if (k == 6) chk("hb3_once", hotbar_valid, 1'b0);
    end
    keycode = 8'h46;
    for (int k = 0; k < 10; k++) begin
      step();
      if (k == 5) begin
        chk("hb9_sel", hotbar_sel, 4'd8);
        chk("hb9_valid", hotbar_valid, 1'b1);
      end
    end
    idle(8);

    // W then D directly
    keycode = 8'h1D;
    for (int k = 0; k < 30; k++) begin
      step();
      if (k == 5) chk("w_held", held, 8'h04);
    end
    keycode = 8'h23;
    for (int k = 0; k < 30; k++) begin
      step();
      if (k == 4) chk("wd_held_old", held, 8'h04);
      if (k == 5) begin
        chk("wd_held_new", held, 8'h02);
        chk("wd_press", press, 8'h02);
      end
      if (k == 25) chk("wd_rpt", repeat_p, REP_EN ? 8'h02 : 8'h00);
    end
    idle(8);

    // pause, break held while paused, unpause
    keycode = 8'h76;
    for (int k = 0; k < 10; k++) begin
      step();
      if (k == 5) chk("pause_on", paused, 1'b1);
    end
    keycode = 8'h3B;
    for (int k = 0; k < 30; k++) begin
      step();
      if (k == 5) begin
        chk("p_held", held, 8'h20);
        chk("p_press", press, 8'h00);
      end
      if (k == 25) chk("p_rpt", repeat_p, 8'h00);
    end
    keycode = 8'h76;
    for (int k = 0; k < 10; k++) begin
      step();
      if (k == 5) chk("pause_off", paused, 1'b0);
    end
    idle(8);

    // reset in the middle of a K hold
    keycode = 8'h42;
    repeat (40) step();
    #2 Reset_h = 1'b1;
    #1 chk("midhold_reset",
           {held, press, repeat_p, hotbar_sel, hotbar_valid, paused}, 0);
    @(negedge Clk);
    Reset_h = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (k == 4) chk("rst_press_pre", press, 8'h00);
      if (k == 5) chk("rst_press", press, 8'h40);
    end
    idle(8);

    // random segments
    pool = '{8'h1C, 8'h23, 8'h1D, 8'h1B, 8'h29, 8'h3B, 8'h42, 8'h24,
             8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
             8'h46, 8'h76, 8'h00, 8'h00, 8'h5A, 8'h76};
    for (int seg = 0; seg < 250; seg++) begin
      int dur;
      if ($urandom_range(0, 39) == 0) begin
        #2 Reset_h = 1'b1;
        @(negedge Clk);
        step();
        Reset_h = 1'b0;
      end
      keycode = pool[$urandom_range(0, 21)];
      dur = ($urandom_range(0, 3) == 0) ? $urandom_range(25, 60)
                                        : $urandom_range(1, 12);
      repeat (dur) step();
    end
    idle(10);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
